mcast_inject_replicator: RTL
============================

# mcast_inject_replicator

Injection-side stage directly upstream of `router_cell`'s host port (`ext_flit_in` / `ext_valid_in` / `ext_ready_out`). It accepts host flits and passes unicast flits through a one-entry register slice. It expands each multicast flit, which carries a destination bitmask, into a sequence of unicast flits, one per set mask bit. Routers therefore only ever see unicast traffic, whether or not their own replication is built.

## Interface
- `FLIT_W`, 64: flit width in bits.
- `ROWS`, 2: mesh rows.
- `COLS`, 2: mesh columns. `ROWS*COLS` must be ≤ 15; larger values fail elaboration.
- `clk`  input  1  clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `up_flit_in`  input  FLIT_W  host flit.
- `up_valid_in`  input  1  host flit valid.
- `up_ready_out`  output  1  block can accept a host flit this cycle.
- `flit_out`  output  FLIT_W  flit to the router's `ext_flit_in`.
- `valid_out`  output  1  to the router's `ext_valid_in`.
- `ready_in`  input  1  from the router's `ext_ready_out`.
- `busy`  output  1  high while in state EMIT.

## Operation
Flit fields:
- [7:0] destination column.
- [15:8] destination row.
- [47:16] payload.
- [62:48] multicast mask. Bit i selects node i, where i = row*COLS + col.
- [63] multicast flag.
- Mask bits at or above `ROWS*COLS` are ignored.

Handshakes:
- Accept: `up_valid_in && up_ready_out`.
- Fire: `valid_out && ready_in`.
- The output register holds `flit_out` / `valid_out` stable until fire.

State machine, states IDLE and EMIT:
- IDLE: `up_ready_out = !valid_out || ready_in`.
- IDLE, accept of a unicast flit ([63]=0): flit loads into the output register unchanged.
- IDLE, accept of a multicast flit with effective mask ≠ 0:
  - The output register loads a copy for the lowest set bit k: [63:48]=0, payload copied, row = k / COLS, col = k % COLS.
  - `mask_q` loads the effective mask with bit k cleared.
  - `payload_q` loads the payload.
  - Go to EMIT if `mask_q` ≠ 0; otherwise stay in IDLE.
- IDLE, accept of a multicast flit with effective mask = 0: flit is consumed and dropped; `valid_out` is not set by it.
- EMIT: `up_ready_out = 0`.
  - On each fire, the output register loads the copy for the lowest set bit of `mask_q`, and that bit is cleared.
  - Return to IDLE in the same cycle the last copy is loaded.
- Copies are emitted in ascending node index, including the node's own index if set.
- Division and modulo use a static lookup over at most 15 entries; there is no iterative divider.
- Reset mid-EMIT: remaining copies are discarded and the in-flight output flit is lost.

## Timing
- Reset values: `valid_out=0`, `flit_out=0`, `busy=0`, state IDLE, `mask_q=0`, `payload_q=0`. `up_ready_out=1` during and after reset.
- Latency: an accepted flit, or the first copy of a multicast flit, appears on `flit_out` the cycle after accept.
- Throughput: one flit per cycle with `ready_in` held high, including back-to-back unicast flits.
- An N-copy multicast flit occupies N consecutive output cycles when unstalled. The next host flit can be accepted in the cycle the last copy fires.
- Stall (`ready_in=0`): the output register and `mask_q` hold; no flit is lost or duplicated.
- Simultaneous accept and fire in IDLE: the old flit leaves and the new flit loads in the same edge.

## Configuration
- `MCAST_INJECT_REPL_EN` defined: replication as described above.
- Undefined:
  - All flits, including multicast and zero-mask flits, pass through unchanged as a one-entry register slice.
  - State stays IDLE and `busy=0` permanently.
  - This build relies on the router's own multicast handling or fallback.

## Test plan
- Reset then idle: `valid_out=0`, `busy=0`, `up_ready_out=1`. Assert `rst` mid-EMIT: the same values hold on the next cycle.
- Unicast `{32'hDEAD_BEEF,8'd1,8'd0}`, `ready_in=1`: identical flit on `flit_out` one cycle later, single beat.
- ROWS=COLS=2, multicast mask 4'b1011, payload 32'hCAFE_0001:
  - Three consecutive beats to (row,col) = (0,0), (0,1), (1,1).
  - Each beat has [63:48]=0 and the same payload.
  - `busy` is high for the first two output cycles.
- Same multicast with `ready_in` toggled 1,0,0,1,1: each copy is held while stalled; exactly three beats in order; `up_ready_out` is low until the last beat fires.
- Multicast mask 0 and mask 15'h7FF0 (bits all ≥4): consumed with no output beat. A following unicast flit emerges one cycle after its accept.
- Build without `MCAST_INJECT_REPL_EN`, multicast mask 4'b1011: a single unchanged beat with [63]=1; `busy` stays 0.

Source files
------------

// File: rtl/mcast_inject_replicator.sv
// Host injection stage: unicast flits pass through a one-entry register slice; multicast
// flits expand into one unicast copy per selected node when MCAST_INJECT_REPL_EN is defined.
module mcast_inject_replicator #(
   parameter int FLIT_W = 64,
   parameter int ROWS   = 2,
   parameter int COLS   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FLIT_W-1:0] up_flit_in,
   input  logic              up_valid_in,
   output logic              up_ready_out,
   output logic [FLIT_W-1:0] flit_out,
   output logic              valid_out,
   input  logic              ready_in,
   output logic              busy
);

   localparam int unsigned NODES = ROWS * COLS;

   generate
      if (ROWS * COLS > 15 || ROWS * COLS < 1) begin : g_bad_size
         $error("mcast_inject_replicator: ROWS*COLS must be in 1..15");
      end
      if (FLIT_W < 64) begin : g_bad_width
         $error("mcast_inject_replicator: FLIT_W must be at least 64");
      end
   endgenerate

   logic [FLIT_W-1:0] flit_q;
   logic              valid_q;

   assign flit_out  = flit_q;
   assign valid_out = valid_q;

`ifdef MCAST_INJECT_REPL_EN
   typedef enum logic {IDLE, EMIT} state_t;

   state_t            state_q, state_d;
   logic [NODES-1:0]  mask_q, mask_d, up_mask;
   logic [31:0]       payload_q, payload_d;
   logic [FLIT_W-1:0] flit_d;
   logic              valid_d, fire, accept;

   // Unicast copy addressed to the lowest selected node; row/col come from an unrolled constant table.
   function automatic logic [FLIT_W-1:0] copy_for(input logic [NODES-1:0] m,
                                                  input logic [31:0]      pl);
      logic [FLIT_W-1:0] f;
      logic              found;
      f       = '0;
      found   = 1'b0;
      f[47:16] = pl;
      for (int unsigned i = 0; i < NODES; i++) begin
         if (!found && m[i]) begin
            found   = 1'b1;
            f[15:8] = 8'(i / COLS);
            f[7:0]  = 8'(i % COLS);
         end
      end
      return f;
   endfunction

   assign up_mask = up_flit_in[48 +: NODES];
   assign busy    = (state_q == EMIT);

   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      payload_d    = payload_q;
      flit_d       = flit_q;
      valid_d      = valid_q;
      up_ready_out = 1'b0;
      accept       = 1'b0;
      fire         = valid_q && ready_in;
      case (state_q)
         IDLE: begin
            up_ready_out = !valid_q || ready_in;
            accept       = up_valid_in && up_ready_out;
            if (fire) valid_d = 1'b0;
            if (accept) begin
               if (!up_flit_in[63]) begin
                  flit_d  = up_flit_in;
                  valid_d = 1'b1;
               end else if (up_mask != '0) begin
                  flit_d    = copy_for(up_mask, up_flit_in[47:16]);
                  valid_d   = 1'b1;
                  mask_d    = up_mask & (up_mask - NODES'(1));
                  payload_d = up_flit_in[47:16];
                  if (mask_d != '0) state_d = EMIT;
               end
            end
         end
         EMIT: begin
            if (fire) begin
               flit_d = copy_for(mask_q, payload_q);
               mask_d = mask_q & (mask_q - NODES'(1));
               if (mask_d == '0) state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         mask_q    <= '0;
         payload_q <= '0;
         flit_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         payload_q <= payload_d;
         flit_q    <= flit_d;
         valid_q   <= valid_d;
      end
   end
`else
   assign up_ready_out = !valid_q || ready_in;
   assign busy         = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flit_q  <= '0;
         valid_q <= 1'b0;
      end else if (up_valid_in && up_ready_out) begin
         flit_q  <= up_flit_in;
         valid_q <= 1'b1;
      end else if (ready_in) begin
         valid_q <= 1'b0;
      end
   end
`endif

endmodule
